pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub.sv | 115 +++++++++++
 tb/tb_pipelined_addsub.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Carry-chunked pipelined adder/subtractor with valid/ready flow control.
// Define PIPELINED_ADDSUB_SAT_EN for saturating signed results (default: wrap).
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW  = WIDTH / STAGES;
  localparam int LS  = STAGES - 1;
  localparam int SKW = (STAGES > 1) ? STAGES - 1 : 1;

  logic             adv;
  logic             v_q    [STAGES];
  logic             c_q    [STAGES];
  logic [WIDTH-1:0] sum_q  [STAGES];
  logic [WIDTH-1:0] ha_q   [SKW];
  logic [WIDTH-1:0] hb_q   [SKW];
  logic             ovf_q;

  logic             v_d    [STAGES];
  logic             c_in   [STAGES];
  logic [WIDTH-1:0] op_a   [STAGES];
  logic [WIDTH-1:0] op_b   [STAGES];
  logic [WIDTH-1:0] sum_in [STAGES];
  logic [CW:0]      chunk  [STAGES];
  logic [WIDTH-1:0] sum_d  [STAGES];
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;

  assign adv       = !v_q[LS] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LS];
  assign s         = sum_q[LS];
  assign cout      = c_q[LS];
  assign ovf       = ovf_q;

  // Operands stay right-aligned in the skew registers so every stage adds
  // bits [CW-1:0]; finished chunks shift in from the top of the deskew word.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign op_a[gi]   = a;
        assign op_b[gi]   = sub ? ~b : b;
        assign c_in[gi]   = sub | cin;
        assign sum_in[gi] = '0;
        assign v_d[gi]    = in_valid;
      end else begin : g_body
        assign op_a[gi]   = ha_q[gi-1];
        assign op_b[gi]   = hb_q[gi-1];
        assign c_in[gi]   = c_q[gi-1];
        assign sum_in[gi] = sum_q[gi-1];
        assign v_d[gi]    = v_q[gi-1];
      end
      assign chunk[gi] = {1'b0, op_a[gi][CW-1:0]} + {1'b0, op_b[gi][CW-1:0]}
                       + {{CW{1'b0}}, c_in[gi]};
      assign sum_d[gi] = (sum_in[gi] >> CW)
                       | (WIDTH'(chunk[gi][CW-1:0]) << (WIDTH - CW));
    end
  endgenerate

  // The last stage holds the operand sign bits, so overflow is decided there.
  assign ovf_d = (op_a[LS][CW-1] == op_b[LS][CW-1])
              && (chunk[LS][CW-1] != op_a[LS][CW-1]);

`ifdef PIPELINED_ADDSUB_SAT_EN
  always_comb begin
    res_d = sum_d[LS];
    if (ovf_d) begin
      res_d = op_a[LS][CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_d = sum_d[LS];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        sum_q[k] <= '0;
      end
      for (int k = 0; k < SKW; k++) begin
        ha_q[k] <= '0;
        hb_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        c_q[k]   <= chunk[k][CW];
        sum_q[k] <= (k == LS) ? res_d : sum_d[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        ha_q[k] <= op_a[k] >> CW;
        hb_q[k] <= op_b[k] >> CW;
      end
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, STAGES=4); honours PIPELINED_ADDSUB_SAT_EN.
module tb_pipelined_addsub;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, cin;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, s;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W+1:0] exp_q[$];
  int           lat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  // Full-width reference: {s, cout, ovf}
  function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fs, input logic fc);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         o;
    bx   = fs ? ~fb : fb;
    full = {1'b0, fa} + {1'b0, bx} + {{W{1'b0}}, (fs | fc)};
    r    = full[W-1:0];
    o    = (fa[W-1] == bx[W-1]) && (r[W-1] != fa[W-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (o) r = fa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {r, full[W], o};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    checks++; if (s !== '0) begin errors++; $display("FAIL rst_s got=%h required=0000", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout got=%b required=0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b required=0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[16], vb[16];
    logic         vs[16], vc[16];
    logic [W+1:0] ve[16];
    logic [W+1:0] got, exp;
    int           n_sent = 0;
    int           lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 0; vc[0] = 0; ve[0] = {16'h0000, 1'b1, 1'b0};
    va[1] = 16'h00FF; vb[1] = 16'h0001; vs[1] = 0; vc[1] = 1; ve[1] = {16'h0101, 1'b0, 1'b0};
    va[2] = 16'h7FFF; vb[2] = 16'h0001; vs[2] = 0; vc[2] = 0;
`ifdef PIPELINED_ADDSUB_SAT_EN
    ve[2] = {16'h7FFF, 1'b0, 1'b1};
`else
    ve[2] = {16'h8000, 1'b0, 1'b1};
`endif
    va[3] = 16'h0005; vb[3] = 16'h0007; vs[3] = 1; vc[3] = 1; ve[3] = {16'hFFFE, 1'b0, 1'b0};
    for (int i = 4; i < 16; i++) begin
      va[i] = W'($urandom()); vb[i] = W'($urandom());
      vs[i] = 1'($urandom()); vc[i] = 1'($urandom());
      if (i == 5) begin va[i] = 16'h8000; vb[i] = 16'h0001; vs[i] = 1'b1; end
      ve[i] = model(va[i], vb[i], vs[i], vc[i]);
    end
    for (int t = 0; t < 80 && (n_sent < 16 || exp_q.size() > 0); t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (n_sent < 16) && ((n_sent < 4) || ($urandom_range(0, 3) != 0));
      if (n_sent < 16) begin
        a = va[n_sent]; b = vb[n_sent]; sub = vs[n_sent]; cin = vc[n_sent];
      end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_in_ready got=%b required=1", in_ready); end
      if (in_valid && in_ready) begin
        exp_q.push_back(ve[n_sent]); lat_q.push_back(cyc); n_sent++;
      end
      if (out_valid && out_ready) begin
        got = {s, cout, ovf};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL vec_unexpected got=%h required=none", got);
        end else begin
          exp = exp_q.pop_front(); lat = lat_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL vec_result got=%h required=%h", got, exp); end
          checks++;
          if (cyc - lat != S) begin errors++; $display("FAIL vec_latency got=%0d required=%0d", cyc - lat, S); end
          $display("retire s=%h cout=%b ovf=%b", s, cout, ovf);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_sent != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL vec_drain got=%0d sent %0d pending required=16 sent 0 pending", n_sent, exp_q.size());
    end
    exp_q.delete(); lat_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[8], tb2[8];
    logic         ts[8], tc[8];
    logic [W+1:0] got, exp;
    int           n_sent = 0, retired = 0, stall_left = 0;
    bit           stalled = 0;
    for (int i = 0; i < 8; i++) begin
      ta[i] = W'($urandom()); tb2[i] = W'($urandom());
      ts[i] = 1'($urandom()); tc[i] = 1'($urandom());
    end
    for (int t = 0; t < 60 && retired < 8; t++) begin
      @(negedge clk);
      if (!stalled && out_valid) begin stalled = 1; stall_left = 3; end
      out_ready = (stall_left == 0);
      in_valid  = (n_sent < 8);
      if (n_sent < 8) begin
        a = ta[n_sent]; b = tb2[n_sent]; sub = ts[n_sent]; cin = tc[n_sent];
      end
      #1;
      if (stall_left > 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || {s, cout, ovf} !== exp_q[0]) begin
          errors++; $display("FAIL stall_hold got=%b/%h required=1/%h", out_valid, {s, cout, ovf},
                             (exp_q.size() == 0) ? '0 : exp_q[0]);
        end
        stall_left--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, cin)); n_sent++;
      end
      if (out_valid && out_ready) begin
        got = {s, cout, ovf};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got=%h required=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL b2b_result got=%h required=%h", got, exp); end
          $display("retire s=%h cout=%b ovf=%b", s, cout, ovf);
        end
        retired++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (retired != 8 || exp_q.size() != 0 || !stalled) begin
      errors++; $display("FAIL b2b_count got=%0d retired required=8", retired);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom()); b = W'($urandom()); sub = 1'b0; cin = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
    checks++; if (s !== '0) begin errors++; $display("FAIL flush_s got=%h required=0000", s); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b required=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale got=%b s=%h required=0", out_valid, s); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
